// File: rtl/ece429_fetch.sv
// Instruction fetch stage: holds the PC, issues one word read at a time over a
// request/grant/response handshake, and presents insn_out/pc_out to decode.
module ece429_fetch #(
  parameter logic [0:31] RESET_PC = 32'h8002_0000,
  parameter int unsigned PC_INCR  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  output logic        mem_req,
  output logic [0:31] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [0:31] mem_rdata,
  output logic [0:31] insn_out,
  output logic [0:31] pc_out,
  output logic        insn_valid,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request is taken when mem_req and mem_gnt are both high at a
  // rising edge; exactly one response (mem_rvalid) follows per taken request.
  // Decode takes the presented instruction at an edge where insn_valid=1 and
  // stall=0. dbg_state encoding: 0=REQ, 1=WAIT, 2=OUT.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [0:31] pc_q;
  logic [0:31] insn_q;
  logic [0:31] pc_out_q;
  logic        valid_q;
  logic        discard_q;

  logic [0:31] pc_next;
  logic [0:31] redirect_tgt;

  assign pc_next      = pc_q + 32'(PC_INCR);
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      insn_q    <= '0;
      pc_out_q  <= '0;
    end else if (redirect_valid) begin
      pc_q    <= redirect_tgt;
      valid_q <= 1'b0;
      // A request already granted must still be drained; mark its data stale.
      case (state_q)
        ST_REQ: begin
          if (mem_gnt) begin
            discard_q <= 1'b1;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            discard_q <= 1'b0;
            state_q   <= ST_REQ;
          end else begin
            discard_q <= 1'b1;
          end
        end
        ST_OUT:  state_q <= ST_REQ;
        default: state_q <= ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (mem_gnt) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= ST_REQ;
            end else begin
              insn_q   <= mem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_next;
              state_q  <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (!stall) begin
            valid_q <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  assign mem_req    = (state_q == ST_REQ) && !reset;
  assign mem_addr   = pc_q;
  assign insn_out   = insn_q;
  assign pc_out     = pc_out_q;
  assign insn_valid = valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ece429_fetch.sv
// Bench for ece429_fetch: responsive memory model, program-order reference
// model in a scoreboard queue, directed scenarios, then a randomized run.
module tb_ece429_fetch;

  localparam logic [31:0] RESET_PC = 32'h8002_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic        mem_req;
  logic [0:31] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [0:31] mem_rdata;
  logic [0:31] insn_out;
  logic [0:31] pc_out;
  logic        insn_valid;
  logic [1:0]  dbg_state;

  ece429_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .insn_out       (insn_out),
    .pc_out         (pc_out),
    .insn_valid     (insn_valid),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- counters and memory contents ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_pres = 0;
  int          idle   = 0;
  logic [31:0] exp_q[$];

  int          gnt_max     = 0;
  int          rv_min      = 0;
  int          rv_max      = 0;
  bit          spurious_en = 1'b0;
  logic [31:0] xor_key     = 32'h0;
  bit          ov_en       = 1'b0;
  logic [31:0] ov_addr     = 32'h0;
  logic [31:0] ov_data     = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return a ^ xor_key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  // Inputs change on the falling edge; grants/responses take effect at the
  // following rising edge. Reset abandons the outstanding request.
  initial begin
    bit          pending;
    bit          granted;
    int          cnt;
    int          gcnt;
    logic [31:0] paddr;
    logic [31:0] gaddr;
    pending = 1'b0; granted = 1'b0; cnt = 0; gcnt = 0; paddr = '0; gaddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        pending = 1'b0; granted = 1'b0; gcnt = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        if (mem_rvalid && pending) pending = 1'b0;
        if (granted) begin
          pending = 1'b1;
          paddr   = gaddr;
          cnt     = $urandom_range(rv_max, rv_min);
          granted = 1'b0;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (pending) begin
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(paddr);
          end else begin
            cnt--;
          end
        end else begin
          if (mem_req) begin
            if (gcnt == 0) begin
              mem_gnt = 1'b1;
              granted = 1'b1;
              gaddr   = mem_addr;
              gcnt    = $urandom_range(gnt_max, 0);
            end else begin
              gcnt--;
            end
          end
          if (spurious_en && $urandom_range(3, 0) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // The queue front is the PC of the next instruction decode should see, in
  // program order: reset PC, +4 per accepted instruction, redirect target.
  always @(negedge clock) begin
    logic [31:0] e;
    if (reset === 1'b1) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      idle = 0;
    end else if (exp_q.size() != 0) begin
      if (insn_valid === 1'b1) begin
        idle = 0;
        e = exp_q[0];
        check("pres_pc", pc_out, e);
        check("pres_insn", insn_out, mem_word(e));
      end else begin
        idle++;
        if (idle > 150) begin
          n_cmp++;
          n_fail++;
          $display("FAIL watchdog: no instruction for %0d cycles, required <= 150", idle);
          idle = 0;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
        idle = 0;
      end else if (insn_valid === 1'b1 && !stall) begin
        e = exp_q.pop_front();
        exp_q.push_back(e + 32'd4);
        n_pres++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_valid", insn_valid, 1'b0);
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int k;
    k = 0;
    while (insn_valid !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    if (insn_valid !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: insn_valid not seen within %0d cycles", name, max);
    end
  endtask

  task automatic wait_req(input string name, input int max);
    int k;
    k = 0;
    while (mem_req !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    check(name, mem_req, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset values
    tick();
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_valid", insn_valid, 1'b0);
    check("reset_insn", insn_out, 32'h0);
    check("reset_pc_out", pc_out, 32'h0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);

    // Sequential fetch, data = address. Counting the final reset edge as the
    // first, the first instruction is valid after the 3rd edge.
    do_reset();
    tick();
    check("t1_edge2_valid", insn_valid, 1'b0);
    tick();
    check("t1_edge3_valid", insn_valid, 1'b1);
    check("t1_pc0", pc_out, RESET_PC);
    check("t1_insn0", insn_out, RESET_PC);
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("t1_req", mem_req, 1'b1);
      check("t1_addr", mem_addr, RESET_PC + 32'(4 * k));
      tick();
      tick();
      check("t1_valid", insn_valid, 1'b1);
      check("t1_pc", pc_out, RESET_PC + 32'(4 * k));
      check("t1_insn", insn_out, RESET_PC + 32'(4 * k));
    end

    // Stall hold
    do_reset();
    ov_en = 1'b1; ov_addr = 32'h8002_0200; ov_data = 32'h2402_0005;
    do_redirect(32'h8002_0200);
    wait_valid("t2_valid", 40);
    check("t2_insn", insn_out, 32'h2402_0005);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_hold_valid", insn_valid, 1'b1);
      check("t2_hold_insn", insn_out, 32'h2402_0005);
      check("t2_hold_pc", pc_out, 32'h8002_0200);
      check("t2_hold_req", mem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    check("t2_next_req", mem_req, 1'b1);
    check("t2_next_addr", mem_addr, 32'h8002_0204);

    // Redirect while waiting for data; the stale word must be dropped
    do_reset();
    ov_en = 1'b1; ov_addr = RESET_PC; ov_data = 32'hDEAD_BEEF;
    rv_min = 2; rv_max = 2;
    tick();
    check("t3_in_wait_req", mem_req, 1'b0);
    check("t3_in_wait_state", {30'd0, dbg_state}, 32'd1);
    do_redirect(32'h8002_0103);
    rv_min = 0; rv_max = 0;
    check("t3_valid_low", insn_valid, 1'b0);
    wait_req("t3_req", 10);
    check("t3_addr", mem_addr, 32'h8002_0100);
    wait_valid("t3_valid", 20);
    check("t3_pc", pc_out, 32'h8002_0100);
    check("t3_insn", insn_out, 32'h8002_0100);

    // Redirect while holding under stall
    do_reset();
    ov_en = 1'b0;
    do_redirect(32'h8002_0010);
    wait_valid("t4_valid", 40);
    check("t4_pc", pc_out, 32'h8002_0010);
    stall = 1'b1;
    tick();
    check("t4_held", insn_valid, 1'b1);
    do_redirect(32'h8002_0040);
    check("t4_dropped", insn_valid, 1'b0);
    check("t4_req", mem_req, 1'b1);
    check("t4_addr", mem_addr, 32'h8002_0040);
    stall = 1'b0;

    // Redirect coinciding with the response
    do_reset();
    do_redirect(32'h8002_0300);
    begin
      int k;
      k = 0;
      while (!(mem_req === 1'b1 && mem_addr === 32'h8002_0300) && k < 20) begin
        tick();
        k++;
      end
    end
    check("t5_req_addr", mem_addr, 32'h8002_0300);
    tick();
    check("t5_in_wait", mem_req, 1'b0);
    do_redirect(32'h8002_0380);
    check("t5_req", mem_req, 1'b1);
    check("t5_addr", mem_addr, 32'h8002_0380);
    check("t5_valid_low", insn_valid, 1'b0);
    tick();
    tick();
    check("t5_valid", insn_valid, 1'b1);
    check("t5_pc", pc_out, 32'h8002_0380);
    check("t5_insn", insn_out, 32'h8002_0380);

    // PC wrap, then reset in the middle of a fetch
    do_reset();
    do_redirect(32'hFFFF_FFFC);
    wait_valid("t6_valid", 40);
    check("t6_pc", pc_out, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_req", mem_req, 1'b1);
    check("t6_wrap_addr", mem_addr, 32'h0);
    tick();
    check("t6_in_wait", mem_req, 1'b0);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", insn_valid, 1'b0);
    check("t6_rst_req", mem_req, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_after_req", mem_req, 1'b1);
    check("t6_after_addr", mem_addr, RESET_PC);
    wait_valid("t6_after_valid", 20);
    check("t6_after_pc", pc_out, RESET_PC);

    // Randomized run: variable memory latency, spurious responses, stalls,
    // redirects (some near the top of the address space)
    do_reset();
    xor_key = $urandom; ov_en = 1'b0;
    gnt_max = 3; rv_min = 0; rv_max = 3; spurious_en = 1'b1;
    n_pres = 0;
    repeat (3000) begin
      stall = ($urandom_range(2, 0) == 0);
      if ($urandom_range(24, 0) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(7, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        else redirect_pc = 32'h8002_0000 + 32'($urandom_range(1023, 0));
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0; stall = 1'b0; spurious_en = 1'b0;
    repeat (30) tick();
    check("rand_progress", {31'd0, (n_pres >= 100)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
